onehot_dispatch: RTL and testbench
==================================

// Module: onehot_dispatch
// PURPOSE
// Inverse-direction companion to the priority encoder. Accepts a stream of encoded
// target indices over a valid/ready handshake and decodes each one to a one-hot strobe.
// Holds each strobe until the selected target acknowledges it, or until a timeout expires.
// Sits between arbitration/grant logic and WIDTH per-target request lines. A 2-entry
// skid buffer keeps s_ready registered and allows back-to-back dispatch.
// PARAMETERS
// WIDTH           4    number of targets; one-hot width (>=2)
// TIMEOUT_CYCLES  0    cycles to wait for ack before dropping the request; 0 = wait forever
// ERR_CNT_W       8    width of the saturating error counter
// PORTS
// clk         in   1                   clock; all logic on rising edge
// rst_n       in   1                   asynchronous, active-low reset
// s_index     in   $clog2(WIDTH)       encoded target index
// s_valid     in   1                   input beat valid
// s_ready     out  1                   input beat accepted when s_valid&&s_ready
// m_onehot    out  WIDTH               decoded strobe, held while m_valid=1
// m_valid     out  1                   strobe active
// m_ack       in   WIDTH               per-target acknowledge
// timeout     out  1                   1-cycle pulse: request dropped after timeout
// stray_ack   out  1                   1-cycle pulse: any m_ack bit outside an active strobe
// err_count   out  ERR_CNT_W           saturating count of bad-index beats plus timeouts
// BEHAVIOUR
// - Reset (rst_n=0, async): s_ready=0, m_valid=0, m_onehot=0, timeout=0, stray_ack=0,
//   err_count=0, both buffer entries empty, timer=0. s_ready rises on the first edge after
//   reset is released. Reset asserted mid-transaction discards all held and buffered beats.
// - Storage: an output register (OUT) plus a skid register (SKID). s_ready = !SKID_full,
//   and it is a registered signal.
// - Accept: s_valid&&s_ready. If s_index>=WIDTH (non-power-of-2 WIDTH only), the beat is
//   consumed, never presented, and err_count increments.
// - A valid beat goes to OUT if OUT is empty or retiring this cycle; otherwise it goes to
//   SKID. The strobe appears on m_onehot/m_valid the cycle after acceptance (latency 1).
//   m_onehot = 1<<index, exactly one bit set while m_valid=1, and 0 while m_valid=0.
// - State machine (OUT):
//     IDLE   -> ACTIVE when a beat is loaded.
//     ACTIVE retires when (m_ack & m_onehot)!=0. A retire is valid in the first cycle
//            m_valid is high.
//     On retire: load from SKID if it is full, else from the input if accepted this cycle,
//     else go to IDLE. A beat that waits one cycle gives back-to-back strobes with m_valid
//     held high, so throughput is 1 per cycle when acks are immediate.
// - Timeout: the timer clears on every load and counts each ACTIVE cycle without a retire.
//   When the timer reaches TIMEOUT_CYCLES, the beat retires as dropped: timeout pulses and
//   err_count increments. Ack and timeout in the same cycle: the ack wins, with no pulse.
// - stray_ack = |(m_ack & ~(m_valid ? m_onehot : 0)). It is registered, so it pulses
//   1 cycle after the stray ack. It has no effect on state.
// - err_count saturates at 2^ERR_CNT_W-1. A bad index and a timeout in the same cycle add 2
//   (still saturating).
// - Ordering: strobes are issued in acceptance order. Nothing is reordered or duplicated.
// TESTING
// 1. WIDTH=4; send idx 2, then 0. Ack each 3 cycles after m_valid rises
//    -> m_onehot=4'b0100, then 4'b0001; latency 1; s_ready never drops.
// 2. m_ack=4'b1111 tied; 8 consecutive beats idx 0..3,0..3
//    -> one strobe per cycle, m_valid stays 1, in order.
// 3. Hold m_ack=0 and push 3 beats -> SKID fills, s_ready=0 after the 2nd beat; the 3rd beat
//    stalls until the ack, then flows.
// 4. TIMEOUT_CYCLES=5, idx 1, no ack -> timeout pulses in the 6th ACTIVE cycle, err_count=1,
//    m_valid=0 next cycle; the same test with the ack in the 6th cycle gives no pulse.
// 5. WIDTH=5, s_index=6 -> beat consumed, no strobe, err_count+1; ERR_CNT_W=2 with 5 bad
//    beats -> err_count=3 (saturated).
// 6. m_ack=4'b1000 while strobe 4'b0001 -> stray_ack pulse, strobe held. Drop rst_n
//    mid-ACTIVE -> all outputs 0 immediately.

Source files
------------

// File: rtl/onehot_dispatch.sv
// onehot_dispatch: accepts encoded target indices over valid/ready and drives a
// held one-hot strobe per beat until the selected target acknowledges it or an
// optional timeout drops it. A two-entry store (output register plus skid
// register) keeps s_ready registered while still allowing one strobe per cycle.
module onehot_dispatch #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(WIDTH)-1:0] s_index,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [WIDTH-1:0]         m_onehot,
  output logic                     m_valid,
  input  logic [WIDTH-1:0]         m_ack,
  output logic                     timeout,
  output logic                     stray_ack,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W:0]     WIDTH_EXT = (IDX_W + 1)'(WIDTH);
  localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     out_onehot_q, out_onehot_d;
  logic [IDX_W-1:0]     skid_idx_q, skid_idx_d;
  logic                 skid_full_q, skid_full_d;
  logic                 s_ready_q;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 stray_q, stray_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic                 accept;
  logic                 idx_ok;
  logic                 load_in;
  logic                 bad_beat;
  logic                 active;
  logic                 ack_hit;
  logic                 tmo_hit;
  logic                 retire;
  logic [ERR_CNT_W+1:0] err_sum;

  function automatic logic [WIDTH-1:0] decode(input logic [IDX_W-1:0] idx);
    decode = WIDTH'(1) << idx;
  endfunction

  // Handshake qualification, retire detection and the saturating error update
  always_comb begin
    accept   = s_valid && s_ready_q;
    idx_ok   = ({1'b0, s_index} < WIDTH_EXT);
    load_in  = accept && idx_ok;
    bad_beat = accept && !idx_ok;
    active   = (state_q == ACTIVE);
    ack_hit  = active && (|(m_ack & out_onehot_q));
    tmo_hit  = (TIMEOUT_CYCLES > 0) && active && !ack_hit && (timer_q == TMR_LIMIT);
    retire   = ack_hit || tmo_hit;
    stray_d  = |(m_ack & ~(active ? out_onehot_q : '0));
    err_sum  = {2'b00, err_q} + (ERR_CNT_W + 2)'(bad_beat) + (ERR_CNT_W + 2)'(tmo_hit);
    err_d    = (err_sum > {2'b00, ERR_MAX}) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
  end

  // Next-state for the output register, skid register and ack timer
  always_comb begin
    state_d      = state_q;
    out_onehot_d = out_onehot_q;
    skid_idx_d   = skid_idx_q;
    skid_full_d  = skid_full_q;
    timer_d      = timer_q;
    if (!active || retire) begin
      if (skid_full_q) begin
        state_d      = ACTIVE;
        out_onehot_d = decode(skid_idx_q);
        timer_d      = '0;
        if (load_in) begin
          skid_idx_d  = s_index;
          skid_full_d = 1'b1;
        end else begin
          skid_full_d = 1'b0;
        end
      end else if (load_in) begin
        state_d      = ACTIVE;
        out_onehot_d = decode(s_index);
        timer_d      = '0;
      end else begin
        state_d      = IDLE;
        out_onehot_d = '0;
        timer_d      = '0;
      end
    end else begin
      if (TIMEOUT_CYCLES > 0) begin
        timer_d = timer_q + 1'b1;
      end
      if (load_in) begin
        skid_idx_d  = s_index;
        skid_full_d = 1'b1;
      end
    end
  end

  // State registers; s_ready is registered from the next skid occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_onehot_q <= '0;
      skid_idx_q   <= '0;
      skid_full_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      timer_q      <= '0;
      stray_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_onehot_q <= out_onehot_d;
      skid_idx_q   <= skid_idx_d;
      skid_full_q  <= skid_full_d;
      s_ready_q    <= !skid_full_d;
      timer_q      <= timer_d;
      stray_q      <= stray_d;
      err_q        <= err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = active;
  assign m_onehot  = out_onehot_q;
  assign timeout   = tmo_hit;
  assign stray_ack = stray_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_onehot_dispatch.sv
// tb_onehot_dispatch: table-driven bench for onehot_dispatch. One instance uses
// WIDTH=4 with a 5-cycle timeout; a second uses WIDTH=5, no timeout and a 2-bit
// error counter for bad-index and saturation cases.
module tb_onehot_dispatch;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [4:0] ack;
    logic       rdy;
    logic       mv;
    logic [4:0] oh;
    logic       to;
    logic       st;
    logic [7:0] err;
  } vec_t;

  logic       clk;
  logic       rst_n;

  logic [1:0] d4_index;
  logic       d4_valid;
  logic       d4_ready;
  logic [3:0] d4_onehot;
  logic       d4_mvalid;
  logic [3:0] d4_ack;
  logic       d4_timeout;
  logic       d4_stray;
  logic [7:0] d4_err;

  logic [2:0] d5_index;
  logic       d5_valid;
  logic       d5_ready;
  logic [4:0] d5_onehot;
  logic       d5_mvalid;
  logic [4:0] d5_ack;
  logic       d5_timeout;
  logic       d5_stray;
  logic [1:0] d5_err;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t tab4[$];
  vec_t tab5[$];

  onehot_dispatch #(.WIDTH(4), .TIMEOUT_CYCLES(5), .ERR_CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_index(d4_index), .s_valid(d4_valid), .s_ready(d4_ready),
    .m_onehot(d4_onehot), .m_valid(d4_mvalid), .m_ack(d4_ack),
    .timeout(d4_timeout), .stray_ack(d4_stray), .err_count(d4_err)
  );

  onehot_dispatch #(.WIDTH(5), .TIMEOUT_CYCLES(0), .ERR_CNT_W(2)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_index(d5_index), .s_valid(d5_valid), .s_ready(d5_ready),
    .m_onehot(d5_onehot), .m_valid(d5_mvalid), .m_ack(d5_ack),
    .timeout(d5_timeout), .stray_ack(d5_stray), .err_count(d5_err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] idx, input logic [4:0] ack,
                              input logic rdy, input logic mv, input logic [4:0] oh,
                              input logic to, input logic st, input logic [7:0] err);
    vec_t r;
    r.v = v; r.idx = idx; r.ack = ack;
    r.rdy = rdy; r.mv = mv; r.oh = oh; r.to = to; r.st = st; r.err = err;
    return r;
  endfunction

  task automatic check_val(input string name, input int row, input logic [7:0] act,
                           input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int which);
    if (which == 0) begin
      d4_valid = v.v;
      d4_index = v.idx[1:0];
      d4_ack   = v.ack[3:0];
    end else begin
      d5_valid = v.v;
      d5_index = v.idx;
      d5_ack   = v.ack;
    end
  endtask

  task automatic check_output(input vec_t v, input int which, input int row);
    string lbl;
    lbl = (which == 0) ? "dut4" : "dut5";
    if (which == 0) begin
      check_val({lbl, " s_ready"},   row, {7'd0, d4_ready},   {7'd0, v.rdy});
      check_val({lbl, " m_valid"},   row, {7'd0, d4_mvalid},  {7'd0, v.mv});
      check_val({lbl, " m_onehot"},  row, {4'd0, d4_onehot},  {3'd0, v.oh});
      check_val({lbl, " timeout"},   row, {7'd0, d4_timeout}, {7'd0, v.to});
      check_val({lbl, " stray_ack"}, row, {7'd0, d4_stray},   {7'd0, v.st});
      check_val({lbl, " err_count"}, row, d4_err,             v.err);
    end else begin
      check_val({lbl, " s_ready"},   row, {7'd0, d5_ready},   {7'd0, v.rdy});
      check_val({lbl, " m_valid"},   row, {7'd0, d5_mvalid},  {7'd0, v.mv});
      check_val({lbl, " m_onehot"},  row, {3'd0, d5_onehot},  {3'd0, v.oh});
      check_val({lbl, " timeout"},   row, {7'd0, d5_timeout}, {7'd0, v.to});
      check_val({lbl, " stray_ack"}, row, {7'd0, d5_stray},   {7'd0, v.st});
      check_val({lbl, " err_count"}, row, {6'd0, d5_err},     v.err);
    end
  endtask

  // Main sequence: reset check, WIDTH=4 table, reset mid-transaction, WIDTH=5 table
  initial begin
    vec_t idle;
    vec_t zero;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // WIDTH=4: rows are {v, idx, ack | s_ready, m_valid, m_onehot, timeout, stray, err}
    tab4.push_back(mk(1, 3, 5'h0, 0, 0, 5'h0, 0, 0, 0));
    tab4.push_back(mk(1, 2, 5'h0, 1, 0, 5'h0, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(1, 0, 5'h4, 1, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h1, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h1, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h1, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h1, 1, 1, 5'h1, 0, 0, 0));
    tab4.push_back(mk(1, 0, 5'hF, 1, 0, 5'h0, 0, 0, 0));
    tab4.push_back(mk(1, 1, 5'hF, 1, 1, 5'h1, 0, 1, 0));
    tab4.push_back(mk(1, 2, 5'hF, 1, 1, 5'h2, 0, 1, 0));
    tab4.push_back(mk(1, 3, 5'hF, 1, 1, 5'h4, 0, 1, 0));
    tab4.push_back(mk(1, 0, 5'hF, 1, 1, 5'h8, 0, 1, 0));
    tab4.push_back(mk(1, 1, 5'hF, 1, 1, 5'h1, 0, 1, 0));
    tab4.push_back(mk(1, 2, 5'hF, 1, 1, 5'h2, 0, 1, 0));
    tab4.push_back(mk(1, 3, 5'hF, 1, 1, 5'h4, 0, 1, 0));
    tab4.push_back(mk(0, 0, 5'hF, 1, 1, 5'h8, 0, 1, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 0, 5'h0, 0, 1, 0));
    tab4.push_back(mk(1, 1, 5'h0, 1, 0, 5'h0, 0, 0, 0));
    tab4.push_back(mk(1, 2, 5'h0, 1, 1, 5'h2, 0, 0, 0));
    tab4.push_back(mk(1, 3, 5'h0, 0, 1, 5'h2, 0, 0, 0));
    tab4.push_back(mk(1, 3, 5'h2, 0, 1, 5'h2, 0, 0, 0));
    tab4.push_back(mk(1, 3, 5'h0, 1, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 0, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h4, 0, 1, 5'h4, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h8, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h8, 1, 1, 5'h8, 0, 0, 0));
    tab4.push_back(mk(1, 1, 5'h0, 1, 0, 5'h0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h2, 0, 0, 0));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h2, 1, 0, 0));
    tab4.push_back(mk(1, 1, 5'h0, 1, 0, 5'h0, 0, 0, 1));
    for (int i = 0; i < 5; i++) tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h2, 0, 0, 1));
    tab4.push_back(mk(0, 0, 5'h2, 1, 1, 5'h2, 0, 0, 1));
    tab4.push_back(mk(1, 0, 5'h0, 1, 0, 5'h0, 0, 0, 1));
    tab4.push_back(mk(0, 0, 5'h8, 1, 1, 5'h1, 0, 0, 1));
    tab4.push_back(mk(0, 0, 5'h0, 1, 1, 5'h1, 0, 1, 1));
    tab4.push_back(mk(1, 2, 5'h0, 1, 1, 5'h1, 0, 0, 1));

    // WIDTH=5, no timeout, 2-bit saturating error counter
    tab5.push_back(mk(1, 6, 5'h00, 1, 0, 5'h00, 0, 0, 0));
    tab5.push_back(mk(0, 0, 5'h00, 1, 0, 5'h00, 0, 0, 1));
    tab5.push_back(mk(1, 4, 5'h00, 1, 0, 5'h00, 0, 0, 1));
    tab5.push_back(mk(1, 7, 5'h00, 1, 1, 5'h10, 0, 0, 1));
    tab5.push_back(mk(1, 5, 5'h00, 1, 1, 5'h10, 0, 0, 2));
    tab5.push_back(mk(1, 6, 5'h00, 1, 1, 5'h10, 0, 0, 3));
    tab5.push_back(mk(1, 6, 5'h00, 1, 1, 5'h10, 0, 0, 3));
    tab5.push_back(mk(1, 5, 5'h00, 1, 1, 5'h10, 0, 0, 3));
    for (int i = 0; i < 5; i++) tab5.push_back(mk(0, 0, 5'h00, 1, 1, 5'h10, 0, 0, 3));
    tab5.push_back(mk(0, 0, 5'h10, 1, 1, 5'h10, 0, 0, 3));
    tab5.push_back(mk(0, 0, 5'h00, 1, 0, 5'h00, 0, 0, 3));

    rst_n = 1'b0;
    apply_stimulus(idle, 0);
    apply_stimulus(idle, 1);
    #2;
    check_output(zero, 0, -1);
    check_output(zero, 1, -1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tab4.size(); i++) begin
      apply_stimulus(tab4[i], 0);
      #1;
      check_output(tab4[i], 0, i);
      @(negedge clk);
    end

    // Skid holds a beat and a strobe is active; reset must discard both at once
    apply_stimulus(idle, 0);
    #1;
    check_val("dut4 skid full s_ready", 100, {7'd0, d4_ready}, 8'd0);
    check_val("dut4 held m_onehot", 100, {4'd0, d4_onehot}, 8'h01);
    rst_n = 1'b0;
    #1;
    check_output(zero, 0, 101);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("dut4 s_ready before edge", 102, {7'd0, d4_ready}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("dut4 post-reset m_valid", 103 + i, {7'd0, d4_mvalid}, 8'd0);
      check_val("dut4 post-reset m_onehot", 103 + i, {4'd0, d4_onehot}, 8'd0);
      check_val("dut4 post-reset s_ready", 103 + i, {7'd0, d4_ready}, 8'd1);
    end

    @(negedge clk);
    for (int i = 0; i < tab5.size(); i++) begin
      apply_stimulus(tab5[i], 1);
      #1;
      check_output(tab5[i], 1, i);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
